// File: rtl/alu_muldiv_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_iterative
//  Purpose  : Multi-cycle M-extension unit (MUL/MULH/MULHSU/MULHU and
//             DIV/DIVU/REM/REMU). Radix-2 shift-add multiplier and restoring
//             divider, one bit per clock, followed by a sign-fix cycle.
//  Options  : MULDIV_EARLY_OUT_EN - multiplies finish as soon as the
//             remaining multiplier bits are all zero.
//  Revision : 1.0 - initial release
// ============================================================================

// Function codes normally come from config.v; these defaults apply when that
// file has not been included ahead of this one.
`ifndef ALU_MUL
`define ALU_MUL    5'h10
`define ALU_MULH   5'h11
`define ALU_MULHSU 5'h12
`define ALU_MULHU  5'h13
`define ALU_DIV    5'h14
`define ALU_DIVU   5'h15
`define ALU_REM    5'h16
`define ALU_REMU   5'h17
`endif

module alu_muldiv_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [4:0]      alu_function,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] F_MUL    = `ALU_MUL;
  localparam logic [4:0] F_MULH   = `ALU_MULH;
  localparam logic [4:0] F_MULHSU = `ALU_MULHSU;
  localparam logic [4:0] F_MULHU  = `ALU_MULHU;
  localparam logic [4:0] F_DIV    = `ALU_DIV;
  localparam logic [4:0] F_DIVU   = `ALU_DIVU;
  localparam logic [4:0] F_REM    = `ALU_REM;
  localparam logic [4:0] F_REMU   = `ALU_REMU;

  localparam logic [CW-1:0] C_ITER = CW'(XLEN);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  // Architectural state
  logic [1:0]        state_q,  state_d;
  logic [4:0]        func_q,   func_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  // acc: multiply = {hi, lo} product accumulator; divide = {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_q,    acc_d;
  // mcand: multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   mcand_q,  mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              neg_p_q,  neg_p_d;   // product / quotient negative
  logic              neg_r_q,  neg_r_d;   // remainder negative
  logic [XLEN-1:0]   result_q, result_d;

  // Input-side decode
  logic            w_in_mul, w_in_div, w_a_signed, w_b_signed;
  logic            w_sign_a, w_sign_b, w_accept;
  logic [XLEN-1:0] w_mag_a, w_mag_b;

  // Iteration and fix-up datapath
  logic              w_run_mul;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN:0]     w_div_shift, w_div_diff;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_div_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_result;

  // Classify the incoming request and form operand magnitudes
  always_comb begin
    w_in_mul   = alu_function inside {F_MUL, F_MULH, F_MULHSU, F_MULHU};
    w_in_div   = alu_function inside {F_DIV, F_DIVU, F_REM, F_REMU};
    w_a_signed = alu_function inside {F_MULH, F_MULHSU, F_DIV, F_REM};
    w_b_signed = alu_function inside {F_MULH, F_DIV, F_REM};
    w_sign_a   = w_a_signed & operand_a[XLEN-1];
    w_sign_b   = w_b_signed & operand_b[XLEN-1];
    w_mag_a    = w_sign_a ? -operand_a : operand_a;
    w_mag_b    = w_sign_b ? -operand_b : operand_b;
    w_accept   = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  end

  // One multiply step (add then shift right) and one restoring-divide step
  always_comb begin
    w_run_mul   = func_q inside {F_MUL, F_MULH, F_MULHSU, F_MULHU};
    w_mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    w_mul_step  = {w_mul_sum, acc_q[XLEN-1:1]};
    w_div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, mcand_q};
    // The shifted remainder is below twice the divisor, so the top bit of the
    // difference is exactly the borrow of the trial subtraction.
    w_div_ge    = ~w_div_diff[XLEN];
    w_div_step  = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                   acc_q[XLEN-2:0], w_div_ge};
  end

  // Sign correction and result selection used in the FIX cycle
  always_comb begin
    w_prod = neg_p_q ? -acc_q : acc_q;
    w_quo  = neg_p_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    w_rem  = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (func_q)
      F_MUL:                      w_fix_result = w_prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  w_fix_result = w_prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              w_fix_result = w_quo;
      F_REM, F_REMU:              w_fix_result = w_rem;
      default:                    w_fix_result = '0;
    endcase
  end

  // Next-state logic: accept, iterate, fix up, then signal done
  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          func_d   = alu_function;
          mcand_d  = '0;
          mplier_d = '0;
          neg_p_d  = 1'b0;
          neg_r_d  = 1'b0;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = S_FIX;
          if (w_in_div && (operand_b == '0)) begin
            // Divide by zero: quotient all ones, remainder is the raw dividend
            acc_d = {operand_a, {XLEN{1'b1}}};
          end else if (w_in_mul) begin
            mcand_d  = w_mag_a;
            mplier_d = w_mag_b;
            neg_p_d  = w_sign_a ^ w_sign_b;
            cnt_d    = C_ITER;
            state_d  = S_RUN;
          end else if (w_in_div) begin
            acc_d   = {{XLEN{1'b0}}, w_mag_a};
            mcand_d = w_mag_b;
            neg_p_d = w_sign_a ^ w_sign_b;
            neg_r_d = w_sign_a;
            cnt_d   = C_ITER;
            state_d = S_RUN;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - C_ONE;
        if (w_run_mul) begin
          acc_d    = w_mul_step;
          mplier_d = mplier_q >> 1;
`ifdef MULDIV_EARLY_OUT_EN
          // Nothing left to add: align the partial product by the skipped
          // iterations in one step and finish.
          if (mplier_q[XLEN-1:1] == '0) begin
            acc_d = w_mul_step >> (cnt_q - C_ONE);
            cnt_d = '0;
          end
`endif
        end else begin
          acc_d = w_div_step;
        end
        if (cnt_d == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        result_d = w_fix_result;
        state_d  = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      func_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_RUN) | (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

`default_nettype wire
